mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped interval timer that answers the CPU's data-memory bus (addr / wdata / wren / rdata) as a responder, alongside data_memory. Software programs a 32-bit compare value, enables the counter and polls or takes an interrupt on match. Reads are combinational so single-cycle loads complete in the same cycle. Writes are byte-lane qualified on the rising clock edge.

## Interface
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; bits [3:0] are ignored.
- PRESCALE_W, 16, width of the prescaler field and counter (max 16).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  CPU byte address (ALU result).
- wdata  input  32  store data.
- wren  input  4  byte-lane write enables; bit i qualifies wdata[8i+7:8i].
- rdata  output  32  read data, combinational.
- hit  output  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4]. The top-level read mux uses it.
- irq  output  1  interrupt request = MATCH & IRQ_EN.

## Operation
- Registers are selected by addr[3:2]. addr[1:0] is ignored.
  - 0x0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[16+PRESCALE_W-1:16] PRESCALE. Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 MATCH (write-1-to-clear), bit1 RUNNING (= EN, read-only). Other bits read 0.
- A write occurs only when hit=1; each lane with wren[i]=1 updates byte i. When wren=0 or hit=0, no register changes.
- rdata = selected register when hit=1, else 32'h0.
- Prescaler:
  - Counts 0..PRESCALE while EN=1.
  - A tick is asserted in the cycle the prescaler equals PRESCALE; the prescaler then returns to 0.
  - The prescaler is held at 0 while EN=0.
- On a tick:
  - If COUNT == COMPARE: MATCH<=1. If PERIODIC=1, COUNT<=0. If PERIODIC=0, EN<=0 and COUNT holds.
  - Otherwise COUNT<=COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0 with no flag).
- Period is (COMPARE+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - CPU write to COUNT beats a tick in the same cycle; the prescaler also clears to 0.
  - New MATCH set beats a W1C clear in the same cycle.
  - One-shot auto-clear of EN beats a CPU write of EN=1 in the same cycle.
  - A CPU write of EN=0 clears the prescaler.
  - A CTRL/COMPARE write takes effect for evaluation in the following cycle.

## Timing
- Reset: CTRL, COUNT, COMPARE, MATCH and the prescaler are 0; irq=0. rdata=0 unless hit, in which case it shows the reset register values.
- Reset mid-count: all state returns to reset values on the next edge; no pending tick survives.
- Read latency: 0 cycles (combinational from addr and current registers).
- Write latency: the register shows the new value one edge after the write cycle.
- From the write of EN=1 with PRESCALE=0 and COUNT=0, the first increment happens at edge +2 (EN registers at +1, first tick at +2).
- MATCH and irq rise on the edge of the matching tick. irq is a function of registers only, so it is glitch-free.

## Configuration
- TIMER_PRESCALER_EN defined: the PRESCALE field and prescaler counter are implemented as above.
- Not defined:
  - No prescaler logic; tick = EN every cycle.
  - CTRL[31:16] reads 0 and writes to it are ignored.
  - PRESCALE_W is unused.

## Test plan
- Reset then read: rst high for 2 cycles, then read 0x0/0x4/0x8/0xC at BASE_ADDR. Expect all rdata=0, irq=0, hit=1; addr=0x0000_1000 gives hit=0, rdata=0.
- Byte lanes: write COMPARE with wdata=0xAABBCCDD, wren=4'b0101 over 0x11223344. Expect COMPARE=0x11BB33DD.
- Periodic irq: COMPARE=3, PRESCALE=0, write CTRL=0x7. Expect MATCH/irq rising every 4 ticks with COUNT sequence 0,1,2,3,0; W1C to STATUS drops irq next edge.
- One-shot with prescaler: COMPARE=2, PRESCALE=4, CTRL=0x1. Expect COUNT to step every 5 cycles, MATCH at the third tick, then EN=0 and COUNT held at 2. Without TIMER_PRESCALER_EN, expect a step every cycle.
- Collisions:
  - COUNT write in a tick cycle: the written value is kept.
  - W1C in a match cycle: MATCH stays 1.
  - COUNT=0xFFFF_FFFF, COMPARE=5: wraps to 0 with no MATCH.
- Reset mid-operation: assert rst while running with irq=1. Next edge: all registers 0, irq=0, counting stopped.

Source files
------------

// File: rtl/mmio_timer_if.sv
// mmio_timer bus bundle: CPU data-memory side (master) and timer (slave).
interface mmio_timer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wren;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (
    output addr, wdata, wren,
    input  rdata, hit, irq
  );

  modport slave (
    input  addr, wdata, wren,
    output rdata, hit, irq
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped interval timer with compare match, periodic/one-shot modes.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus
);

  logic        r_en;
  logic        r_per;
  logic        r_ien;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] r_psc;
`else
  localparam int unused_prescale_w = PRESCALE_W;
`endif

  logic        w_hit;
  logic [1:0]  w_sel;
  logic        w_we;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  logic [31:0] w_ctrl;
  logic [31:0] w_ctrl_n;
  logic [31:0] w_count_n;
  logic [31:0] w_cmp_n;
  logic        w_tick;
  logic        w_fire;
  logic        w_eq;
  logic        w_match_set;
  logic        w_w1c;
  logic        w_unused;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  assign w_hit = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel = bus.addr[3:2];
  assign w_we  = w_hit && (|bus.wren);

  assign w_wr_ctrl  = w_we && (w_sel == 2'd0);
  assign w_wr_count = w_we && (w_sel == 2'd1);
  assign w_wr_cmp   = w_we && (w_sel == 2'd2);
  assign w_wr_stat  = w_we && (w_sel == 2'd3);

  always_comb begin
    w_ctrl    = '0;
    w_ctrl[0] = r_en;
    w_ctrl[1] = r_per;
    w_ctrl[2] = r_ien;
`ifdef TIMER_PRESCALER_EN
    w_ctrl[16 +: PRESCALE_W] = r_pre;
`endif
  end

  assign w_ctrl_n  = merge(w_ctrl, bus.wdata, bus.wren);
  assign w_count_n = merge(r_count, bus.wdata, bus.wren);
  assign w_cmp_n   = merge(r_cmp, bus.wdata, bus.wren);

`ifdef TIMER_PRESCALER_EN
  assign w_tick = r_en && (r_psc == r_pre);
`else
  assign w_tick = r_en;
`endif

  // A COUNT write in the tick cycle cancels that tick entirely
  assign w_fire      = w_tick && !w_wr_count;
  assign w_eq        = (r_count == r_cmp);
  assign w_match_set = w_fire && w_eq;
  assign w_w1c       = w_wr_stat && bus.wren[0] && bus.wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_per   <= 1'b0;
      r_ien   <= 1'b0;
      r_count <= '0;
      r_cmp   <= '0;
      r_match <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      r_pre   <= '0;
      r_psc   <= '0;
`endif
    end else begin
      if (w_wr_ctrl) begin
        r_en  <= w_ctrl_n[0];
        r_per <= w_ctrl_n[1];
        r_ien <= w_ctrl_n[2];
`ifdef TIMER_PRESCALER_EN
        r_pre <= w_ctrl_n[16 +: PRESCALE_W];
`endif
      end
      if (w_match_set && !r_per)
        r_en <= 1'b0;

      if (w_wr_count)
        r_count <= w_count_n;
      else if (w_fire) begin
        if (!w_eq)
          r_count <= r_count + 32'd1;
        else if (r_per)
          r_count <= '0;
      end

      if (w_wr_cmp)
        r_cmp <= w_cmp_n;

      if (w_match_set)
        r_match <= 1'b1;
      else if (w_w1c)
        r_match <= 1'b0;

`ifdef TIMER_PRESCALER_EN
      if (!r_en || w_tick || w_wr_count ||
          (w_wr_ctrl && !w_ctrl_n[0]))
        r_psc <= '0;
      else
        r_psc <= r_psc + 1'b1;
`endif
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (w_hit) begin
      unique case (w_sel)
        2'd0: bus.rdata = w_ctrl;
        2'd1: bus.rdata = r_count;
        2'd2: bus.rdata = r_cmp;
        2'd3: bus.rdata = {30'd0, r_en, r_match};
      endcase
    end
  end

  assign bus.hit = w_hit;
  assign bus.irq = r_match & r_ien;

  assign w_unused = &{1'b0, bus.addr[1:0], w_ctrl_n};

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer.
// Expectations adapt to TIMER_PRESCALER_EN where behaviour differs.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CNT  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

`ifdef TIMER_PRESCALER_EN
  localparam int          STEP   = 5;
  localparam logic [31:0] OS_CTL = 32'h0004_0001;
`else
  localparam int          STEP   = 1;
  localparam logic [31:0] OS_CTL = 32'h0000_0001;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mmio_timer_if bus ();

  mmio_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.wren  = be;
    @(posedge clk);
    #1;
    bus.wren  = 4'h0;
    bus.wdata = '0;
  endtask

  task automatic rd(
    input logic [31:0] a,
    input logic [31:0] exp,
    input string       tag
  );
    bus.wren = 4'h0;
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic tic();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.addr  = BASE;
    bus.wdata = '0;
    bus.wren  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_CNT,  32'h0, "rst_count");
    rd(A_CMP,  32'h0, "rst_cmp");
    rd(A_STAT, 32'h0, "rst_stat");
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_hit", {31'd0, bus.hit}, 32'd1);
    rd(32'h0000_1000, 32'h0, "miss_rdata");
    check("miss_hit", {31'd0, bus.hit}, 32'd0);

    // byte lanes and miss writes
    wr(A_CMP, 32'h1122_3344, 4'hF);
    wr(A_CMP, 32'hAABB_CCDD, 4'b0101);
    rd(A_CMP, 32'h11BB_33DD, "lanes_cmp");
    wr(32'h0000_1008, 32'hDEAD_BEEF, 4'hF);
    rd(A_CMP, 32'h11BB_33DD, "miss_write");
    rd(A_CMP + 32'h3, 32'h11BB_33DD, "addr_low_ign");

    // periodic with irq
    wr(A_CMP, 32'd3, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    rd(A_CNT, 32'd0, "per_c0");
    for (int i = 1; i <= 3; i++) begin
      tic();
      rd(A_CNT, i, "per_step");
      check("per_noirq", {31'd0, bus.irq}, 32'd0);
    end
    tic();
    rd(A_CNT, 32'd0, "per_wrap");
    rd(A_STAT, 32'h3, "per_stat");
    check("per_irq", {31'd0, bus.irq}, 32'd1);
    wr(A_STAT, 32'h1, 4'h1);
    check("w1c_irq", {31'd0, bus.irq}, 32'd0);
    rd(A_CNT, 32'd1, "w1c_count");
    tic();
    tic();
    rd(A_CNT, 32'd3, "pre_match");
    // W1C lands in the matching tick cycle
    wr(A_STAT, 32'h1, 4'h1);
    rd(A_STAT, 32'h3, "w1c_vs_set");
    check("w1c_vs_irq", {31'd0, bus.irq}, 32'd1);
    rd(A_CNT, 32'd0, "w1c_vs_cnt");
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h1, 4'h1);
    rd(A_STAT, 32'h0, "stop_stat");
    rd(A_CNT, 32'd1, "stop_cnt");

    // one-shot, prescaled when available
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CMP, 32'd2, 4'hF);
    wr(A_CTRL, 32'h0004_0001, 4'hF);
    rd(A_CTRL, OS_CTL, "os_ctrl");
    for (int k = 1; k <= 2; k++) begin
      repeat (STEP) tic();
      rd(A_CNT, k, "os_step");
    end
    repeat (STEP) tic();
    rd(A_STAT, 32'h1, "os_stat");
    rd(A_CNT, 32'd2, "os_hold");
    rd(A_CTRL, OS_CTL & 32'hFFFF_FFFE, "os_ctrl_off");
    repeat (STEP) tic();
    rd(A_CNT, 32'd2, "os_hold2");

    // COUNT write versus tick
    wr(A_STAT, 32'h1, 4'h1);
    wr(A_CMP, 32'd100, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    wr(A_CNT, 32'h50, 4'hF);
    rd(A_CNT, 32'h50, "cntwr_keep");
    tic();
    rd(A_CNT, 32'h51, "cntwr_next");

    // wrap without match
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
    rd(A_CNT, 32'hFFFF_FFFF, "wrap_max");
    tic();
    rd(A_CNT, 32'd0, "wrap_zero");
    rd(A_STAT, 32'h2, "wrap_nomatch");

    // reset while irq is asserted
    wr(A_CTRL, 32'h7, 4'hF);
    for (int i = 0; i < 20 && !bus.irq; i++) tic();
    check("wait_irq", {31'd0, bus.irq}, 32'd1);
    rst = 1'b1;
    tic();
    rst = 1'b0;
    rd(A_CTRL, 32'h0, "mrst_ctrl");
    rd(A_CNT,  32'h0, "mrst_cnt");
    rd(A_CMP,  32'h0, "mrst_cmp");
    check("mrst_irq", {31'd0, bus.irq}, 32'd0);
    tic();
    tic();
    rd(A_CNT,  32'h0, "mrst_stopped");
    rd(A_STAT, 32'h0, "mrst_stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
